// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a same-cycle Mealy match, a registered Moore match
// and a saturating match counter. Pattern MSB is the first bit received.
module seq_detector_param #(
  parameter int unsigned          SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0]   PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             mealy_out,
  output logic             moore_out,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned        FILL_W   = ($clog2(SEQ_LEN) < 1) ? 1 : $clog2(SEQ_LEN);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(SEQ_LEN - 1);

  if (SEQ_LEN < 2 || SEQ_LEN > 32) begin : g_bad_seq_len
    $error("seq_detector_param: SEQ_LEN must be in 2..32");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be in 1..32");
  end

  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               moore_q, moore_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEQ_LEN-1:0] window;
  logic               match;

  always_comb begin
    window  = {hist_q, in};
    match   = en & ~rst & (fill_q == FILL_MAX) & (window == PATTERN);
    hist_d  = hist_q;
    fill_d  = fill_q;
    moore_d = moore_q;
    cnt_d   = cnt_q;

    // History and Moore state advance only on accepted bits
    if (en) begin
      moore_d = match;
      if (match && !OVERLAP) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[SEQ_LEN-2:0];
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      moore_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      moore_q <= moore_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mealy_out   = match;
  assign moore_out   = moore_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream; each scenario task checks the instance it concerns.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       en = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       ov_mealy, ov_moore;
  logic [7:0] ov_cnt;
  logic       nov_mealy, nov_moore;
  logic [7:0] nov_cnt;
  logic       sat_mealy, sat_moore;
  logic [1:0] sat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .in(in), .en(en), .cnt_clr(cnt_clr),
    .mealy_out(ov_mealy), .moore_out(ov_moore), .match_count(ov_cnt));

  seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .in(in), .en(en), .cnt_clr(cnt_clr),
    .mealy_out(nov_mealy), .moore_out(nov_moore), .match_count(nov_cnt));

  seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in(in), .en(en), .cnt_clr(cnt_clr),
    .mealy_out(sat_mealy), .moore_out(sat_moore), .match_count(sat_cnt));

  // Drive one cycle's inputs at the falling edge; outputs are settled 1 time unit later.
  task automatic put(input logic b, input logic e, input logic c);
    @(negedge clk);
    rst = 1'b0; in = b; en = e; cnt_clr = c;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in = 1'b0; en = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; in = 1'b1; cnt_clr = 1'b0;
    #1;
    total++;
    if (ov_mealy !== 1'b0) begin bad++; $display("FAIL reset_mealy_forced got=%b want=0", ov_mealy); end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; in = 1'b0;
    #1;
    total++;
    if (ov_moore !== 1'b0) begin bad++; $display("FAIL reset_moore got=%b want=0", ov_moore); end
    total++;
    if (ov_cnt !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ov_cnt); end
    total++;
    if (sat_cnt !== 2'd0) begin bad++; $display("FAIL reset_sat_count got=%0d want=0", sat_cnt); end
  endtask

  task automatic test_basic();
    logic [3:0] s = 4'b1011;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      put(s[3-i], 1'b1, 1'b0);
      total++;
      if (ov_mealy !== (i == 3)) begin
        bad++; $display("FAIL basic_mealy bit%0d got=%b want=%b", i, ov_mealy, (i == 3));
      end
      if (i == 3) begin
        total++;
        if (ov_moore !== 1'b0) begin bad++; $display("FAIL basic_moore_early got=%b want=0", ov_moore); end
      end
    end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (ov_moore !== 1'b1) begin bad++; $display("FAIL basic_moore got=%b want=1", ov_moore); end
    total++;
    if (ov_cnt !== 8'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", ov_cnt); end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (ov_moore !== 1'b0) begin bad++; $display("FAIL basic_moore_fall got=%b want=0", ov_moore); end
  endtask

  task automatic test_overlap();
    logic [6:0] s    = 7'b1011011;
    logic [6:0] m_ov = 7'b0001001;
    logic [6:0] m_no = 7'b0001000;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      put(s[6-i], 1'b1, 1'b0);
      total++;
      if (ov_mealy !== m_ov[6-i]) begin
        bad++; $display("FAIL overlap_on_mealy bit%0d got=%b want=%b", i, ov_mealy, m_ov[6-i]);
      end
      total++;
      if (nov_mealy !== m_no[6-i]) begin
        bad++; $display("FAIL overlap_off_mealy bit%0d got=%b want=%b", i, nov_mealy, m_no[6-i]);
      end
    end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (ov_cnt !== 8'd2) begin bad++; $display("FAIL overlap_on_count got=%0d want=2", ov_cnt); end
    total++;
    if (nov_cnt !== 8'd1) begin bad++; $display("FAIL overlap_off_count got=%0d want=1", nov_cnt); end
  endtask

  task automatic test_negative();
    logic [3:0] s0 = 4'b0010;
    logic [4:0] s1 = 5'b11011;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      put(s0[3-i], 1'b1, 1'b0);
      total++;
      if (ov_mealy !== 1'b0 || ov_moore !== 1'b0) begin
        bad++; $display("FAIL negative_quiet bit%0d got=%b%b want=00", i, ov_mealy, ov_moore);
      end
    end
    put(1'b0, 1'b0, 1'b0);
    total++;
    if (ov_cnt !== 8'd0) begin bad++; $display("FAIL negative_count got=%0d want=0", ov_cnt); end
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      put(s1[4-i], 1'b1, 1'b0);
      total++;
      if (ov_mealy !== (i == 4)) begin
        bad++; $display("FAIL noisy_mealy bit%0d got=%b want=%b", i, ov_mealy, (i == 4));
      end
    end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (ov_cnt !== 8'd1) begin bad++; $display("FAIL noisy_count got=%0d want=1", ov_cnt); end
  endtask

  task automatic test_enable_gap();
    apply_reset();
    put(1'b1, 1'b1, 1'b0);
    put(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 1'b0, 1'b0);
      total++;
      if (ov_mealy !== 1'b0) begin bad++; $display("FAIL gap_mealy_idle cyc%0d got=%b want=0", i, ov_mealy); end
    end
    put(1'b1, 1'b1, 1'b0);
    total++;
    if (ov_mealy !== 1'b0) begin bad++; $display("FAIL gap_mealy_third got=%b want=0", ov_mealy); end
    put(1'b1, 1'b1, 1'b0);
    total++;
    if (ov_mealy !== 1'b1) begin bad++; $display("FAIL gap_mealy_match got=%b want=1", ov_mealy); end
    for (int i = 0; i < 2; i++) begin
      put(1'b1, 1'b0, 1'b0);
      total++;
      if (ov_moore !== 1'b1 || ov_mealy !== 1'b0) begin
        bad++; $display("FAIL gap_moore_hold cyc%0d got=%b%b want=10", i, ov_moore, ov_mealy);
      end
    end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (ov_moore !== 1'b1) begin bad++; $display("FAIL gap_moore_before_accept got=%b want=1", ov_moore); end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (ov_moore !== 1'b0) begin bad++; $display("FAIL gap_moore_after_accept got=%b want=0", ov_moore); end
  endtask

  task automatic test_mid_reset();
    logic [2:0] s = 3'b011;
    apply_reset();
    put(1'b1, 1'b1, 1'b0);
    put(1'b0, 1'b1, 1'b0);
    put(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; in = 1'b0;
    put(1'b1, 1'b1, 1'b0);
    total++;
    if (ov_mealy !== 1'b0) begin bad++; $display("FAIL midrst_no_match got=%b want=0", ov_mealy); end
    for (int i = 0; i < 3; i++) begin
      put(s[2-i], 1'b1, 1'b0);
      total++;
      if (ov_mealy !== (i == 2)) begin
        bad++; $display("FAIL midrst_mealy bit%0d got=%b want=%b", i, ov_mealy, (i == 2));
      end
    end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (ov_cnt !== 8'd1) begin bad++; $display("FAIL midrst_count got=%0d want=1", ov_cnt); end
  endtask

  task automatic test_saturation();
    logic [15:0] s = 16'b1011_0110_1101_1011;
    logic [15:0] m = 16'b0001_0010_0100_1001;
    logic [1:0]  want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int k = 0;
    logic prev_match = 1'b0;
    apply_reset();
    for (int i = 0; i <= 16; i++) begin
      put((i < 16) ? s[15-i] : 1'b0, 1'b1, 1'b0);
      if (prev_match) begin
        total++;
        if (sat_cnt !== want[k]) begin
          bad++; $display("FAIL sat_count match%0d got=%0d want=%0d", k, sat_cnt, want[k]);
        end
        k++;
      end
      if (i < 16) begin
        total++;
        if (sat_mealy !== m[15-i]) begin
          bad++; $display("FAIL sat_mealy bit%0d got=%b want=%b", i, sat_mealy, m[15-i]);
        end
      end
      prev_match = (i < 16) ? m[15-i] : 1'b0;
    end
    total++;
    if (ov_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide_count got=%0d want=5", ov_cnt); end
    // history now ends in ...1,0 (last put was 0 after the final 1011)
    put(1'b1, 1'b1, 1'b0);
    put(1'b1, 1'b1, 1'b1);
    total++;
    if (sat_mealy !== 1'b1) begin bad++; $display("FAIL clr_mealy got=%b want=1", sat_mealy); end
    put(1'b0, 1'b1, 1'b0);
    total++;
    if (sat_cnt !== 2'd0) begin bad++; $display("FAIL clr_sat_count got=%0d want=0", sat_cnt); end
    total++;
    if (ov_cnt !== 8'd0) begin bad++; $display("FAIL clr_wide_count got=%0d want=0", ov_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_negative();
    test_enable_gap();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; next generation of the fixed 1011 Mealy/Moore detectors.
- Pattern, length and overlap mode are set at elaboration.
- Provides both a Mealy (same-cycle) and a Moore (registered) match output from one instance, plus a qualifying enable and a saturating match counter.
- Sits on a serial bit stream beside or in place of the fixed-pattern detectors.

Parameters:
- SEQ_LEN, 4, pattern length in bits; legal range 2..32; elaboration error outside this range.
- PATTERN, 4'b1011, target pattern, SEQ_LEN bits wide; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, match counter width; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in  input  1  serial data bit.
- en  input  1  sample qualifier; in is accepted only on cycles with en=1.
- cnt_clr  input  1  synchronous clear of match_count.
- mealy_out  output  1  combinational match, valid in the cycle the final pattern bit is accepted.
- moore_out  output  1  registered match state.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset: single clock; rst is sampled on the rising edge of clk and has priority over all other inputs.
- On reset: history register and fill count clear to 0; moore_out=0; match_count=0.
- mealy_out is forced to 0 combinationally while rst=1.
- State:
  - hist[SEQ_LEN-2:0] shift register holds the most recent accepted bits.
  - fill counter (0..SEQ_LEN-1) counts valid history bits; saturates at SEQ_LEN-1.
- match (combinational) = en & ~rst & (fill == SEQ_LEN-1) & ({hist, in} == PATTERN).
- mealy_out = match. Zero latency: high in the same cycle as the last pattern bit. Never high when en=0.
- Accepted bit (en=1, no match, or a match with OVERLAP=1): hist <= {hist[SEQ_LEN-3:0], in} and fill <= min(fill+1, SEQ_LEN-1).
- Accepted bit with match and OVERLAP=0: hist <= 0 and fill <= 0. The final matching bit is not reused.
- en=0: hist and fill hold; the in value is ignored.
- moore_out:
  - Updates only on cycles with en=1: moore_out <= match.
  - Holds its value while en=0, so it stays high across enable gaps until the next accepted bit.
  - Latency: exactly one clock after mealy_out for the same match.
- match_count:
  - On cnt_clr=1: clears to 0. cnt_clr has priority over a simultaneous match; that match is not counted.
  - Otherwise increments by 1 on each match and saturates at 2^CNT_W-1 with no wrap.
- Reset mid-sequence discards partial progress; a full SEQ_LEN accepted bits are required after rst falls.
- No match is possible until SEQ_LEN bits have been accepted since reset, or since the last match when OVERLAP=0.
- Width rules: comparisons are exactly SEQ_LEN bits wide; match_count is unsigned CNT_W bits.

Test Plan:
Defaults unless stated: PATTERN=1011, SEQ_LEN=4, en=1, one bit per clock.
- Basic match: rst for 1 cycle, then bits 1,0,1,1 -> mealy_out=1 only in the 4th bit's cycle; moore_out=1 in the following cycle; match_count=1.
- Overlap, OVERLAP=1, stream 1,0,1,1,0,1,1 -> mealy_out pulses on bits 4 and 7; match_count=2.
- Overlap, OVERLAP=0, same stream -> single pulse on bit 4; match_count=1.
- Negative and noisy start:
  - Stream 0,0,1,0 -> mealy_out and moore_out stay 0; match_count=0.
  - Then stream 1,1,0,1,1 -> exactly one match on the final bit.
- Enable gaps: bits 1,0, then en=0 for 3 cycles with in=1, then bits 1,1 -> match on the last bit.
  - While en=0, mealy_out=0.
  - Afterwards hold en=0 for 2 cycles -> moore_out stays 1 until the next accepted bit.
- Reset mid-sequence: bits 1,0,1, then rst=1 for 1 cycle, then bit 1 -> no match.
  - Then bits 0,1,1 -> match; match_count=1.
- Saturation and clear, CNT_W=2: 5 back-to-back overlapping matches -> match_count goes 1,2,3,3,3.
  - Assert cnt_clr in the same cycle as a match -> match_count=0 next cycle.
